// File: rtl/cic_pkg.sv
// rtl/cic_pkg.sv - shared widths and helpers for the CIC decimation filter
package cic_pkg;

    localparam int MAX_COMB_STAGES    = 8;
    localparam int CIC_DATA_WIDTH_IN  = 20;
    localparam int CIC_DATA_WIDTH_OUT = 16;

    function automatic int clog2(input int value);
        int result;
        int v;
        result = 0;
        v      = value - 1;
        while (v > 0) begin
            result = result + 1;
            v      = v >> 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/comb_stage.sv
// rtl/comb_stage.sv - one CIC comb difference with its differential delay line
module comb_stage
    import cic_pkg::*;
#(
    parameter int DATA_WIDTH = CIC_DATA_WIDTH_IN,
    parameter int DIFF_DELAY = 1
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         strobe_i,
    input  logic signed [DATA_WIDTH-1:0] x_i,
    output logic                         strobe_o,
    output logic signed [DATA_WIDTH-1:0] y_o
);

    logic signed [DATA_WIDTH-1:0] d_q [DIFF_DELAY];
    logic signed [DATA_WIDTH-1:0] y_q;
    logic signed [DATA_WIDTH-1:0] y_d;
    logic                         strobe_q;

    // Modular difference: integrator overflow cancels here, so no saturation.
    always_comb begin
        y_d = x_i - d_q[DIFF_DELAY-1];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            y_q      <= '0;
            strobe_q <= 1'b0;
            for (int i = 0; i < DIFF_DELAY; i++) begin
                d_q[i] <= '0;
            end
        end else begin
            strobe_q <= strobe_i;
            if (strobe_i) begin
                y_q    <= y_d;
                d_q[0] <= x_i;
                for (int i = 1; i < DIFF_DELAY; i++) begin
                    d_q[i] <= d_q[i-1];
                end
            end
        end
    end

    assign y_o      = y_q;
    assign strobe_o = strobe_q;

endmodule

// File: rtl/cic_comb_decim.sv
// rtl/cic_comb_decim.sv - CIC decimator, comb chain and output shift/saturate
module cic_comb_decim
    import cic_pkg::*;
#(
    parameter int DATA_WIDTH_IN  = CIC_DATA_WIDTH_IN,
    parameter int DATA_WIDTH_OUT = CIC_DATA_WIDTH_OUT,
    parameter int NUM_STAGES     = 3,
    parameter int DIFF_DELAY     = 1,
    parameter int MAX_DECIM      = 16,
    parameter int CNT_WIDTH      = clog2(MAX_DECIM + 1)
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             en,
    input  logic signed [DATA_WIDTH_IN-1:0]  in,
    input  logic [CNT_WIDTH-1:0]             decim_factor,
    input  logic [4:0]                       out_shift,
    output logic signed [DATA_WIDTH_OUT-1:0] out,
    output logic                             out_valid,
    output logic                             sat
);

    localparam logic [CNT_WIDTH-1:0] ONE   = CNT_WIDTH'(1);
    localparam logic [CNT_WIDTH-1:0] MAX_R = CNT_WIDTH'(MAX_DECIM);
    localparam logic signed [DATA_WIDTH_IN-1:0] OUT_MAX =
        DATA_WIDTH_IN'((1 <<< (DATA_WIDTH_OUT - 1)) - 1);
    localparam logic signed [DATA_WIDTH_IN-1:0] OUT_MIN =
        DATA_WIDTH_IN'(-(1 <<< (DATA_WIDTH_OUT - 1)));

    logic [CNT_WIDTH-1:0]               r_active_q, r_active_d;
    logic [CNT_WIDTH-1:0]               cnt_q, cnt_d;
    logic                               keep;
    logic signed [DATA_WIDTH_IN-1:0]    x0_q;
    logic                               v0_q;

    logic signed [DATA_WIDTH_IN-1:0]    stage_x [NUM_STAGES+1];
    logic                               stage_v [NUM_STAGES+1];

    logic signed [DATA_WIDTH_IN-1:0]    shifted;
    logic signed [DATA_WIDTH_OUT-1:0]   out_d;
    logic                               sat_d;
    logic signed [DATA_WIDTH_OUT-1:0]   out_q;
    logic                               sat_q;
    logic                               out_valid_q;

    always_comb begin
        keep       = en && ((r_active_q <= ONE) || (cnt_q == r_active_q - ONE));
        cnt_d      = cnt_q;
        if (en) begin
            cnt_d = keep ? '0 : cnt_q + ONE;
        end
        r_active_d = (decim_factor > MAX_R) ? MAX_R : decim_factor;
    end

    // R only changes on frame boundaries so a mid-frame write cannot shorten the current frame.
    always_ff @(posedge clk) begin
        if (rst || keep) begin
            r_active_q <= r_active_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
            x0_q  <= '0;
            v0_q  <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            v0_q  <= keep;
            if (keep) begin
                x0_q <= in;
            end
        end
    end

    assign stage_x[0] = x0_q;
    assign stage_v[0] = v0_q;

    for (genvar k = 0; k < NUM_STAGES; k++) begin : g_comb
        comb_stage #(
            .DATA_WIDTH (DATA_WIDTH_IN),
            .DIFF_DELAY (DIFF_DELAY)
        ) u_comb (
            .clk      (clk),
            .rst      (rst),
            .strobe_i (stage_v[k]),
            .x_i      (stage_x[k]),
            .strobe_o (stage_v[k+1]),
            .y_o      (stage_x[k+1])
        );
    end

    always_comb begin
        shifted = stage_x[NUM_STAGES] >>> out_shift;
        sat_d   = 1'b0;
        out_d   = shifted[DATA_WIDTH_OUT-1:0];
        if (shifted > OUT_MAX) begin
            out_d = OUT_MAX[DATA_WIDTH_OUT-1:0];
            sat_d = 1'b1;
        end else if (shifted < OUT_MIN) begin
            out_d = OUT_MIN[DATA_WIDTH_OUT-1:0];
            sat_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_q       <= '0;
            sat_q       <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            out_valid_q <= stage_v[NUM_STAGES];
            if (stage_v[NUM_STAGES]) begin
                out_q <= out_d;
                sat_q <= sat_d;
            end
        end
    end

    assign out       = out_q;
    assign sat       = sat_q;
    assign out_valid = out_valid_q;

endmodule

// File: tb/tb_cic_comb_decim.sv
// tb/tb_cic_comb_decim.sv - self-checking bench for cic_comb_decim
module tb_cic_comb_decim;

    localparam int N    = 3;
    localparam int M    = 1;
    localparam int MAXD = 16;
    localparam int LAT  = N + 2;

    logic               clk = 1'b0;
    logic               rst = 1'b0;
    logic               en = 1'b0;
    logic signed [19:0] din = '0;
    logic [4:0]         decim_factor = 5'd1;
    logic [4:0]         out_shift = 5'd0;
    logic signed [15:0] dout;
    logic               out_valid;
    logic               sat;

    always #5 clk = ~clk;

    cic_comb_decim dut (
        .clk          (clk),
        .rst          (rst),
        .en           (en),
        .in           (din),
        .decim_factor (decim_factor),
        .out_shift    (out_shift),
        .out          (dout),
        .out_valid    (out_valid),
        .sat          (sat)
    );

    typedef struct {
        longint val;
        logic   s;
        int     due;
    } exp_t;

    exp_t   expq[$];
    longint kept[$];
    longint log_v[$];
    logic   log_s[$];
    int     checks = 0;
    int     failures = 0;
    int     cyc = 0;
    int     m_r = 1;
    int     m_cnt = 0;

    always @(posedge clk) cyc++;

    task automatic chk(input string name, input longint act, input longint req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    function automatic longint wrap20(input longint v);
        logic signed [19:0] t;
        t = v[19:0];
        return longint'(t);
    endfunction

    function automatic longint binom(input int n, input int k);
        longint r;
        r = 1;
        for (int i = 0; i < k; i++) r = r * (n - i) / (i + 1);
        return r;
    endfunction

    function automatic int clampr(input int d);
        return (d > MAXD) ? MAXD : d;
    endfunction

    // N-th order difference with lag M, written as a binomial sum over kept history.
    function automatic void model_push();
        int     n;
        longint acc;
        longint y;
        longint v;
        exp_t   e;
        n   = kept.size() - 1;
        acc = 0;
        for (int j = 0; j <= N; j++) begin
            if (n - j * M >= 0)
                acc += ((j % 2) ? -1 : 1) * binom(N, j) * kept[n - j * M];
        end
        y = wrap20(acc);
        v = y >>> out_shift;
        e.s = 1'b0;
        if (v > 32767)       begin v = 32767;  e.s = 1'b1; end
        else if (v < -32768) begin v = -32768; e.s = 1'b1; end
        e.val = v;
        e.due = cyc + LAT;
        expq.push_back(e);
    endfunction

    task automatic step(input logic e, input longint d);
        en  = e;
        din = d[19:0];
        if (e) begin
            m_cnt++;
            if (m_r <= 1 || m_cnt == m_r) begin
                kept.push_back(wrap20(d));
                model_push();
                m_cnt = 0;
                m_r   = clampr(int'(decim_factor));
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) step(1'b0, 0);
    endtask

    task automatic do_reset(input string name);
        rst = 1'b1;
        en  = 1'b0;
        expq.delete();
        kept.delete();
        #1;
        chk({name, "_rst_out"}, dout, 0);
        chk({name, "_rst_valid"}, out_valid, 0);
        chk({name, "_rst_sat"}, sat, 0);
        repeat (2) @(posedge clk);
        #1;
        rst   = 1'b0;
        m_cnt = 0;
        m_r   = clampr(int'(decim_factor));
        log_v.delete();
        log_s.delete();
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (out_valid) begin
                log_v.push_back(dout);
                log_s.push_back(sat);
                if (expq.size() == 0) begin
                    chk("unexpected_valid", 1, 0);
                end else begin
                    exp_t e;
                    e = expq.pop_front();
                    chk("valid_time", cyc, e.due);
                    chk("out", dout, e.val);
                    chk("sat", sat, e.s);
                end
            end else if (expq.size() > 0 && expq[0].due <= cyc) begin
                chk("missing_valid", cyc, expq[0].due);
                void'(expq.pop_front());
            end
        end
    end

    task automatic chk_log(input string name, input int idx, input longint v, input logic s);
        if (idx < log_v.size()) begin
            chk({name, "_val"}, log_v[idx], v);
            chk({name, "_sat"}, log_s[idx], s);
        end else begin
            chk({name, "_present"}, log_v.size(), idx + 1);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL timeout actual=%0d required=0", cyc);
        $fatal(1, "timeout");
    end

    initial begin
        longint s3;
        #2;
        // Constant input, R=1
        decim_factor = 5'd1;
        out_shift    = 5'd0;
        do_reset("t1");
        repeat (8) step(1'b1, 100);
        idle(8);
        chk_log("t1_0", 0, 100, 0);
        chk_log("t1_1", 1, -200, 0);
        chk_log("t1_2", 2, 100, 0);
        chk_log("t1_3", 3, 0, 0);
        chk_log("t1_4", 4, 0, 0);

        // Decimation R=4 on a ramp
        decim_factor = 5'd4;
        do_reset("t2");
        for (int i = 0; i < 16; i++) step(1'b1, i);
        idle(8);
        chk("t2_count", log_v.size(), 4);
        chk_log("t2_0", 0, 3, 0);
        chk_log("t2_1", 1, -2, 0);
        chk_log("t2_2", 2, -1, 0);
        chk_log("t2_3", 3, 0, 0);

        // Ramp across the 20-bit wrap
        decim_factor = 5'd1;
        do_reset("t3");
        s3 = 524287 - 10000;
        for (int i = 0; i < 30; i++) step(1'b1, s3 + 1000 * i);
        idle(8);
        for (int i = 3; i < 30; i += 6) chk_log("t3_zero", i, 0, 0);

        // Saturation and shift
        do_reset("t4a");
        step(1'b1, 40000);
        step(1'b1, 80000);
        idle(8);
        chk_log("t4_pos", 0, 32767, 1);
        chk_log("t4_neg", 1, -32768, 1);
        out_shift = 5'd2;
        do_reset("t4b");
        step(1'b1, 40000);
        idle(8);
        chk_log("t4_shift2", 0, 10000, 0);
        out_shift = 5'd1;
        do_reset("t4c");
        step(1'b1, -5);
        idle(8);
        chk_log("t4_floor", 0, -3, 0);
        out_shift = 5'd0;

        // Gated en and mid-frame R change
        decim_factor = 5'd4;
        do_reset("t5");
        for (int i = 0; i < 20; i++) step(i % 2 == 0, i);
        decim_factor = 5'd2;
        for (int i = 20; i < 32; i++) step(i % 2 == 0, i);
        idle(8);
        chk("t5_count", log_v.size(), 5);

        // decim_factor above MAX_DECIM clamps
        decim_factor = 5'd31;
        do_reset("t5b");
        for (int i = 0; i < 32; i++) step(1'b1, 5 * i);
        idle(8);
        chk("t5b_count", log_v.size(), 2);
        chk_log("t5b_0", 0, 75, 0);

        // Reset with samples in flight
        decim_factor = 5'd2;
        do_reset("t6a");
        for (int i = 0; i < 5; i++) step(1'b1, 10 * i + 50);
        do_reset("t6b");
        step(1'b1, 7);
        step(1'b1, 9);
        idle(8);
        chk("t6_count", log_v.size(), 1);
        chk_log("t6_0", 0, 9, 0);

        idle(4);
        chk("queue_drained", expq.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
